// File: rtl/ccip_host_mem_responder.sv
// Host-side CCI-P memory model: queued c0 reads with programmable latency, c1 writes with acks.
// Optional bounds checking is enabled by defining CCIP_HOST_MEM_BOUNDS_CHECK_EN.
module ccip_host_mem_responder #(
  parameter int ADDR_W        = 42,
  parameter int DATA_W        = 512,
  parameter int MEM_LINES     = 16,
  parameter int FIFO_DEPTH    = 8,
  parameter int ALMFULL_SLACK = 4,
  parameter int RD_LATENCY    = 3
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              c0_req_valid,
  input  logic [ADDR_W-1:0] c0_req_addr,
  input  logic [15:0]       c0_req_mdata,
  input  logic              c1_req_valid,
  input  logic              c1_req_sop,
  input  logic [ADDR_W-1:0] c1_req_addr,
  input  logic [15:0]       c1_req_mdata,
  input  logic [DATA_W-1:0] c1_req_data,
  output logic              c0_rsp_valid,
  output logic [15:0]       c0_rsp_mdata,
  output logic [DATA_W-1:0] c0_rsp_data,
  output logic              c1_rsp_valid,
  output logic [15:0]       c1_rsp_mdata,
  output logic              c0_alm_full,
  output logic              c1_alm_full,
  output logic              ovf_err,
  output logic              addr_err
);

  localparam int IDX_W = $clog2(MEM_LINES);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int OCC_W = PTR_W + 1;
  localparam int CNT_W = ($clog2(RD_LATENCY + 1) < 1) ? 1 : $clog2(RD_LATENCY + 1);
  localparam int RQ_W  = 1 + IDX_W + 16;
  localparam logic [OCC_W-1:0] FULL_OCC   = OCC_W'(FIFO_DEPTH);
  localparam logic [OCC_W-1:0] ALM_THRESH = OCC_W'(FIFO_DEPTH - ALMFULL_SLACK);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic c0_req_oob;
  logic c1_req_oob;

`ifdef CCIP_HOST_MEM_BOUNDS_CHECK_EN
  assign c0_req_oob = |c0_req_addr[ADDR_W-1:IDX_W];
  assign c1_req_oob = |c1_req_addr[ADDR_W-1:IDX_W];
`else
  // Addresses wrap modulo MEM_LINES; upper bits are intentionally ignored.
  logic unused_upper_addr;
  assign unused_upper_addr = ^{c0_req_addr[ADDR_W-1:IDX_W], c1_req_addr[ADDR_W-1:IDX_W]};
  assign c0_req_oob = 1'b0;
  assign c1_req_oob = 1'b0;
`endif

  logic [DATA_W-1:0] mem [MEM_LINES];

  logic [RQ_W-1:0]  rdq_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] rdq_wr_ptr_reg, rdq_rd_ptr_reg;
  logic [OCC_W-1:0] rdq_occ_reg, rdq_occ_next;
  logic             rdq_push, rdq_pop, rdq_full;

  logic [15:0]      ackq_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] ackq_wr_ptr_reg, ackq_rd_ptr_reg;
  logic [OCC_W-1:0] ackq_occ_reg, ackq_occ_next;
  logic             ackq_req, ackq_accept, ackq_store, ackq_pop, ackq_full;

  logic [1:0]        state_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              hold_oob_reg;
  logic [IDX_W-1:0]  hold_idx_reg;
  logic [15:0]       hold_mdata_reg;

  logic              c0_rsp_valid_reg, c1_rsp_valid_reg;
  logic [15:0]       c0_rsp_mdata_reg, c1_rsp_mdata_reg;
  logic [DATA_W-1:0] c0_rsp_data_reg;
  logic              c0_alm_full_reg, c1_alm_full_reg;
  logic              ovf_err_reg, addr_err_reg;

  always_comb begin
    rdq_pop      = (state_reg == IDLE) && (rdq_occ_reg != '0);
    rdq_full     = (rdq_occ_reg == FULL_OCC);
    rdq_push     = c0_req_valid && (!rdq_full || rdq_pop);
    rdq_occ_next = rdq_occ_reg;
    if (rdq_push && !rdq_pop)
      rdq_occ_next = rdq_occ_reg + OCC_W'(1);
    else if (!rdq_push && rdq_pop)
      rdq_occ_next = rdq_occ_reg - OCC_W'(1);
  end

  // An ack arriving at an empty queue bypasses storage so the minimum ack latency is one cycle.
  always_comb begin
    ackq_req      = c1_req_valid && c1_req_sop;
    ackq_pop      = (ackq_occ_reg != '0);
    ackq_full     = (ackq_occ_reg == FULL_OCC);
    ackq_accept   = ackq_req && (!ackq_full || ackq_pop);
    ackq_store    = ackq_accept && ackq_pop;
    ackq_occ_next = ackq_occ_reg;
    if (ackq_store && !ackq_pop)
      ackq_occ_next = ackq_occ_reg + OCC_W'(1);
    else if (!ackq_store && ackq_pop)
      ackq_occ_next = ackq_occ_reg - OCC_W'(1);
  end

  always_ff @(posedge clk) begin
    if (ackq_accept && !c1_req_oob)
      mem[c1_req_addr[IDX_W-1:0]] <= c1_req_data;
    if (rdq_push)
      rdq_mem[rdq_wr_ptr_reg] <= {c0_req_oob, c0_req_addr[IDX_W-1:0], c0_req_mdata};
    if (ackq_store)
      ackq_mem[ackq_wr_ptr_reg] <= c1_req_mdata;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdq_wr_ptr_reg   <= '0;
      rdq_rd_ptr_reg   <= '0;
      rdq_occ_reg      <= '0;
      ackq_wr_ptr_reg  <= '0;
      ackq_rd_ptr_reg  <= '0;
      ackq_occ_reg     <= '0;
      state_reg        <= IDLE;
      cnt_reg          <= '0;
      hold_oob_reg     <= 1'b0;
      hold_idx_reg     <= '0;
      hold_mdata_reg   <= '0;
      c0_rsp_valid_reg <= 1'b0;
      c0_rsp_mdata_reg <= '0;
      c0_rsp_data_reg  <= '0;
      c1_rsp_valid_reg <= 1'b0;
      c1_rsp_mdata_reg <= '0;
      c0_alm_full_reg  <= 1'b0;
      c1_alm_full_reg  <= 1'b0;
      ovf_err_reg      <= 1'b0;
      addr_err_reg     <= 1'b0;
    end else begin
      rdq_occ_reg     <= rdq_occ_next;
      ackq_occ_reg    <= ackq_occ_next;
      c0_alm_full_reg <= (rdq_occ_next >= ALM_THRESH);
      c1_alm_full_reg <= (ackq_occ_next >= ALM_THRESH);
      if (rdq_push)   rdq_wr_ptr_reg  <= rdq_wr_ptr_reg + PTR_W'(1);
      if (rdq_pop)    rdq_rd_ptr_reg  <= rdq_rd_ptr_reg + PTR_W'(1);
      if (ackq_store) ackq_wr_ptr_reg <= ackq_wr_ptr_reg + PTR_W'(1);
      if (ackq_pop)   ackq_rd_ptr_reg <= ackq_rd_ptr_reg + PTR_W'(1);

      ovf_err_reg  <= ovf_err_reg | (c0_req_valid && !rdq_push) | (ackq_req && !ackq_accept);
      addr_err_reg <= addr_err_reg | (rdq_push && c0_req_oob) | (ackq_accept && c1_req_oob);

      c1_rsp_valid_reg <= ackq_accept || ackq_pop;
      if (ackq_pop)
        c1_rsp_mdata_reg <= ackq_mem[ackq_rd_ptr_reg];
      else if (ackq_accept)
        c1_rsp_mdata_reg <= c1_req_mdata;

      c0_rsp_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (rdq_pop) begin
            {hold_oob_reg, hold_idx_reg, hold_mdata_reg} <= rdq_mem[rdq_rd_ptr_reg];
            cnt_reg <= CNT_W'(RD_LATENCY);
            if (RD_LATENCY > 0)
              state_reg <= WAIT;
            else
              state_reg <= RESP;
          end
        end
        WAIT: begin
          if (cnt_reg == CNT_W'(1))
            state_reg <= RESP;
          else
            cnt_reg <= cnt_reg - CNT_W'(1);
        end
        RESP: begin
          // Memory is sampled before any same-edge write lands (read-before-write).
          c0_rsp_valid_reg <= 1'b1;
          c0_rsp_mdata_reg <= hold_mdata_reg;
          c0_rsp_data_reg  <= hold_oob_reg ? {DATA_W{1'b1}} : mem[hold_idx_reg];
          state_reg        <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign c0_rsp_valid = c0_rsp_valid_reg;
  assign c0_rsp_mdata = c0_rsp_mdata_reg;
  assign c0_rsp_data  = c0_rsp_data_reg;
  assign c1_rsp_valid = c1_rsp_valid_reg;
  assign c1_rsp_mdata = c1_rsp_mdata_reg;
  assign c0_alm_full  = c0_alm_full_reg;
  assign c1_alm_full  = c1_alm_full_reg;
  assign ovf_err      = ovf_err_reg;
  assign addr_err     = addr_err_reg;

endmodule

// File: tb/tb_ccip_host_mem_responder.sv
// Directed bench for ccip_host_mem_responder (default parameters, RD_LATENCY = 3).
module tb_ccip_host_mem_responder;

  localparam int DW = 512;
  localparam int AW = 42;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          c0_req_valid;
  logic [AW-1:0] c0_req_addr;
  logic [15:0]   c0_req_mdata;
  logic          c1_req_valid;
  logic          c1_req_sop;
  logic [AW-1:0] c1_req_addr;
  logic [15:0]   c1_req_mdata;
  logic [DW-1:0] c1_req_data;
  logic          c0_rsp_valid;
  logic [15:0]   c0_rsp_mdata;
  logic [DW-1:0] c0_rsp_data;
  logic          c1_rsp_valid;
  logic [15:0]   c1_rsp_mdata;
  logic          c0_alm_full;
  logic          c1_alm_full;
  logic          ovf_err;
  logic          addr_err;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int issue_cyc;
  int t0;

  int            c0_cyc_q[$];
  logic [15:0]   c0_md_q[$];
  logic [DW-1:0] c0_dat_q[$];
  int            c1_cyc_q[$];
  logic [15:0]   c1_md_q[$];

  ccip_host_mem_responder dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .c0_req_valid (c0_req_valid),
    .c0_req_addr  (c0_req_addr),
    .c0_req_mdata (c0_req_mdata),
    .c1_req_valid (c1_req_valid),
    .c1_req_sop   (c1_req_sop),
    .c1_req_addr  (c1_req_addr),
    .c1_req_mdata (c1_req_mdata),
    .c1_req_data  (c1_req_data),
    .c0_rsp_valid (c0_rsp_valid),
    .c0_rsp_mdata (c0_rsp_mdata),
    .c0_rsp_data  (c0_rsp_data),
    .c1_rsp_valid (c1_rsp_valid),
    .c1_rsp_mdata (c1_rsp_mdata),
    .c0_alm_full  (c0_alm_full),
    .c1_alm_full  (c1_alm_full),
    .ovf_err      (ovf_err),
    .addr_err     (addr_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Responses are captured mid-cycle together with the cycle they appeared in.
  always @(negedge clk) begin
    if (c0_rsp_valid) begin
      c0_cyc_q.push_back(cyc);
      c0_md_q.push_back(c0_rsp_mdata);
      c0_dat_q.push_back(c0_rsp_data);
      $display("c0 rsp: cyc=%0d mdata=%0h data[31:0]=%0h", cyc, c0_rsp_mdata, c0_rsp_data[31:0]);
    end
    if (c1_rsp_valid) begin
      c1_cyc_q.push_back(cyc);
      c1_md_q.push_back(c1_rsp_mdata);
      $display("c1 ack: cyc=%0d mdata=%0h", cyc, c1_rsp_mdata);
    end
  end

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_q();
    c0_cyc_q.delete();
    c0_md_q.delete();
    c0_dat_q.delete();
    c1_cyc_q.delete();
    c1_md_q.delete();
  endtask

  // Called at a negedge; the strobe is sampled at the following posedge.
  task automatic rd_req(input logic [AW-1:0] a, input logic [15:0] md);
    c0_req_valid = 1'b1;
    c0_req_addr  = a;
    c0_req_mdata = md;
    issue_cyc    = cyc;
    @(negedge clk);
    c0_req_valid = 1'b0;
  endtask

  task automatic wr_req(input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input logic [15:0] md, input logic sop);
    c1_req_valid = 1'b1;
    c1_req_sop   = sop;
    c1_req_addr  = a;
    c1_req_data  = d;
    c1_req_mdata = md;
    issue_cyc    = cyc;
    @(negedge clk);
    c1_req_valid = 1'b0;
  endtask

  initial begin
    reset_n      = 1'b0;
    c0_req_valid = 1'b0;
    c0_req_addr  = '0;
    c0_req_mdata = '0;
    c1_req_valid = 1'b0;
    c1_req_sop   = 1'b0;
    c1_req_addr  = '0;
    c1_req_mdata = '0;
    c1_req_data  = '0;

    repeat (3) @(negedge clk);
    check("rst_c0_valid", DW'(c0_rsp_valid), DW'(0));
    check("rst_c1_valid", DW'(c1_rsp_valid), DW'(0));
    check("rst_c0_alm",   DW'(c0_alm_full),  DW'(0));
    check("rst_c1_alm",   DW'(c1_alm_full),  DW'(0));
    check("rst_ovf",      DW'(ovf_err),      DW'(0));
    check("rst_addr_err", DW'(addr_err),     DW'(0));
    check("rst_c0_data",  c0_rsp_data,       DW'(0));
    reset_n = 1'b1;
    @(negedge clk);

    // Write line 2, then read it back.
    clear_q();
    wr_req(42'd2, 512'h0A0B00, 16'h11, 1'b1);
    t0 = issue_cyc;
    repeat (3) @(negedge clk);
    check("wr_ack_count", DW'(c1_md_q.size()), DW'(1));
    if (c1_md_q.size() > 0) begin
      check("wr_ack_mdata", DW'(c1_md_q[0]), DW'(16'h11));
      check("wr_ack_lat",   DW'(c1_cyc_q[0] - t0), DW'(1));
    end
    rd_req(42'd2, 16'h22);
    t0 = issue_cyc;
    repeat (10) @(negedge clk);
    check("rd_count", DW'(c0_md_q.size()), DW'(1));
    if (c0_md_q.size() > 0) begin
      check("rd_mdata", DW'(c0_md_q[0]), DW'(16'h22));
      check("rd_data_23_8", DW'(c0_dat_q[0][23:8]), DW'(16'h0A0B));
      check("rd_data", c0_dat_q[0], DW'(24'h0A0B00));
      check("rd_lat", DW'(c0_cyc_q[0] - t0), DW'(6));
    end

    // Back-to-back writes: one ack per cycle, in order.
    clear_q();
    for (int i = 0; i < 3; i++) wr_req(AW'(6 + i), DW'(32'hC000 + i), 16'h201 + 16'(i), 1'b1);
    repeat (3) @(negedge clk);
    check("b2b_ack_count", DW'(c1_md_q.size()), DW'(3));
    for (int i = 0; i < 3; i++)
      if (i < c1_md_q.size()) check("b2b_ack_mdata", DW'(c1_md_q[i]), DW'(16'h201 + 16'(i)));
    rd_req(42'd7, 16'h2FF);
    repeat (10) @(negedge clk);
    if (c0_dat_q.size() > 0) check("b2b_rd_line7", c0_dat_q[0], DW'(32'hC001));
    else check("b2b_rd_count", DW'(0), DW'(1));

    // Back-to-back reads fill the queue; 11th strobe overflows.
    clear_q();
    for (int i = 0; i < 11; i++) begin
      rd_req(42'd2, 16'h100 + 16'(i));
      if (i == 0) t0 = issue_cyc;
      if (i == 3) check("alm_occ3", DW'(c0_alm_full), DW'(0));
      if (i == 4) check("alm_occ4", DW'(c0_alm_full), DW'(1));
      if (i == 9) begin
        check("alm_full8", DW'(c0_alm_full), DW'(1));
        check("ovf_before", DW'(ovf_err), DW'(0));
      end
    end
    check("ovf_after", DW'(ovf_err), DW'(1));
    repeat (60) @(negedge clk);
    check("burst_count", DW'(c0_md_q.size()), DW'(10));
    for (int j = 0; j < 10; j++)
      if (j < c0_md_q.size()) check("burst_order", DW'(c0_md_q[j]), DW'(16'h100 + 16'(j)));
    if (c0_cyc_q.size() == 10) begin
      check("burst_first_lat", DW'(c0_cyc_q[0] - t0), DW'(6));
      check("burst_last_lat",  DW'(c0_cyc_q[9] - t0), DW'(51));
    end
    check("alm_drained", DW'(c0_alm_full), DW'(0));

    // Write at the RESP edge of a read of the same line.
    clear_q();
    wr_req(42'd5, DW'(8'h01), 16'h44, 1'b1);
    repeat (3) @(negedge clk);
    rd_req(42'd5, 16'h55);
    t0 = issue_cyc;
    repeat (4) @(negedge clk);
    wr_req(42'd5, DW'(8'hFF), 16'h66, 1'b1);
    repeat (6) @(negedge clk);
    if (c0_dat_q.size() > 0) begin
      check("rbw_lat",  DW'(c0_cyc_q[0] - t0), DW'(6));
      check("rbw_data", c0_dat_q[0], DW'(8'h01));
    end else check("rbw_count", DW'(0), DW'(1));
    clear_q();
    rd_req(42'd5, 16'h77);
    repeat (10) @(negedge clk);
    if (c0_dat_q.size() > 0) check("rbw_after", c0_dat_q[0], DW'(8'hFF));
    else check("rbw_after_count", DW'(0), DW'(1));

    // Out-of-range read address 18.
    clear_q();
    rd_req(42'd18, 16'h88);
    repeat (10) @(negedge clk);
    if (c0_dat_q.size() > 0) begin
      check("oob_mdata", DW'(c0_md_q[0]), DW'(16'h88));
`ifdef CCIP_HOST_MEM_BOUNDS_CHECK_EN
      check("oob_data", c0_dat_q[0], {DW{1'b1}});
`else
      check("oob_data", c0_dat_q[0], DW'(24'h0A0B00));
`endif
    end else check("oob_count", DW'(0), DW'(1));
`ifdef CCIP_HOST_MEM_BOUNDS_CHECK_EN
    check("oob_addr_err", DW'(addr_err), DW'(1));
`else
    check("oob_addr_err", DW'(addr_err), DW'(0));
`endif

    // Write with sop = 0 is dropped.
    clear_q();
    wr_req(42'd2, DW'(16'hDEAD), 16'h99, 1'b0);
    repeat (3) @(negedge clk);
    check("nosop_ack_count", DW'(c1_md_q.size()), DW'(0));
    rd_req(42'd2, 16'hAA);
    repeat (10) @(negedge clk);
    if (c0_dat_q.size() > 0) check("nosop_mem", c0_dat_q[0], DW'(24'h0A0B00));
    else check("nosop_rd_count", DW'(0), DW'(1));

    // Reset while the FSM waits.
    clear_q();
    check("ovf_sticky", DW'(ovf_err), DW'(1));
    rd_req(42'd2, 16'hBB);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst_ovf", DW'(ovf_err), DW'(0));
    check("midrst_c0_valid", DW'(c0_rsp_valid), DW'(0));
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    check("midrst_no_rsp", DW'(c0_md_q.size()), DW'(0));
    check("midrst_c0_alm", DW'(c0_alm_full), DW'(0));
    check("midrst_c1_alm", DW'(c1_alm_full), DW'(0));
    rd_req(42'd2, 16'hCC);
    t0 = issue_cyc;
    repeat (10) @(negedge clk);
    check("postrst_count", DW'(c0_md_q.size()), DW'(1));
    if (c0_md_q.size() > 0) begin
      check("postrst_mdata", DW'(c0_md_q[0]), DW'(16'hCC));
      check("postrst_lat", DW'(c0_cyc_q[0] - t0), DW'(6));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
